pedo_cmd_sequencer: RTL
=======================

Name: pedo_cmd_sequencer

Overview:
- Host-side initiator for the pedometer core's command interface.
- Parses a byte stream from the host (valid/ready) into command frames.
- Drives the core's countSteps / updateWeights / dualUpdateWeights strobes with operands A, B, Addr1, Data1, Addr2, Data2, holding each strobe until the core accepts it.
- Coalesces consecutive weight writes into dual updates to halve weight-load cycles.

Parameters:
- FLUSH_TIMEOUT, 16, idle cycles with a pending single weight before it is issued alone; 0 disables the timeout.
- TMR_W, 5, timeout counter width; must hold FLUSH_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  sequencer accepts in_data this cycle.
- cmd_ready  in  1  core accepts the currently asserted strobe this cycle.
- countSteps  out  1  count command strobe.
- updateWeights  out  1  single weight-write strobe.
- dualUpdateWeights  out  1  dual weight-write strobe.
- A, B  out  8 each  count operands.
- Addr1, Addr2  out  3 each  weight addresses.
- Data1, Data2  out  8 each  weight data.
- err_opcode  out  1  sticky flag: a reserved header was received.

Behaviour:
- Frame format:
  - Header bits [7:6]: 00 COUNT, 01 WEIGHT, 10 FLUSH, 11 reserved.
  - COUNT and WEIGHT each take two argument bytes. COUNT: A, then B. WEIGHT: addr (bits [2:0] used, [7:3] ignored), then data.
- Handshake:
  - A byte transfers when in_valid && in_ready.
  - A strobe completes when strobe && cmd_ready.
  - At most one strobe is high at any time.
  - While a strobe is high it and its operands stay stable until accepted.
  - When no strobe is high, all operand outputs are 0.
- Pending register: holds one (addr, data) weight plus a valid bit.
- FSM states: HDR, ARG0, ARG1, ISSUE_W, ISSUE_D, ISSUE_C.
  - in_ready = 1 only in HDR, ARG0 and ARG1.
  - Strobe outputs are registered and high exactly in ISSUE_W (updateWeights), ISSUE_D (dualUpdateWeights) and ISSUE_C (countSteps).
- HDR transitions:
  - COUNT or WEIGHT -> ARG0.
  - FLUSH -> ISSUE_W if pending, else stay in HDR.
  - Reserved -> set err_opcode, byte dropped, stay in HDR.
- ARG0: on accept, latch arg0 -> ARG1.
- ARG1: on accept, latch arg1, then:
  - COUNT with pending -> ISSUE_W, then ISSUE_C.
  - COUNT without pending -> ISSUE_C.
  - WEIGHT with no pending -> load pending -> HDR.
  - WEIGHT with pending at the same address -> overwrite pending data (last write wins) -> HDR; no strobe.
  - WEIGHT with pending at a different address -> ISSUE_D with Addr1/Data1 = pending and Addr2/Data2 = new.
- ISSUE_W: Addr1/Data1 = pending. On accept, clear pending; go to ISSUE_C if the frame is COUNT, else HDR.
- ISSUE_D: on accept, clear pending -> HDR.
- ISSUE_C: on accept -> HDR.
- Timeout:
  - The counter runs in HDR while pending && !in_valid, and clears otherwise.
  - On reaching FLUSH_TIMEOUT -> ISSUE_W.
  - An in_valid in the same cycle takes precedence and resets the counter.
- Latency:
  - A strobe asserts the cycle after the accepting edge of the final argument byte.
  - After acceptance, the next header is accepted the following cycle.
  - Best-case throughput: one dual update per 7 cycles.
- Reset mid-operation:
  - Returns to HDR and drops any partial frame and pending weight.
  - All outputs go to 0, including err_opcode, in_ready and the strobes.
- err_opcode clears only on reset.

Decomposition:
- Shared package pedo_pkg:
  - header opcode constants (CMD_COUNT=2'b00, CMD_WEIGHT=2'b01, CMD_FLUSH=2'b10).
  - FSM state encoding.
  - ADDR_W=3, DATA_W=8.
- One natural sub-module, pedo_frame_parser: the HDR/ARG0/ARG1 byte collector with the in_ready handshake. It outputs a one-cycle frame_valid with opcode, arg0 and arg1. The issue FSM, pending register and timer stay in the top.

Test Plan:
- COUNT: bytes 00,3C,5A with cmd_ready=1 -> countSteps high for exactly 1 cycle with A=3C, B=5A; all other strobes 0.
- Pairing: WEIGHT(2,11) then WEIGHT(5,22) -> a single dualUpdateWeights with Addr1=2, Data1=11, Addr2=5, Data2=22; no updateWeights.
- Same address: WEIGHT(4,AA), WEIGHT(4,BB), FLUSH -> no strobe until FLUSH, then one updateWeights with Addr1=4, Data1=BB.
- Backpressure and ordering: WEIGHT(1,07) then COUNT(10,20) with cmd_ready=0 for 5 cycles -> updateWeights held stable with Addr1=1, Data1=07 and in_ready=0. After acceptance, countSteps follows with A=10, B=20.
- Timeout and reset:
  - WEIGHT(6,33), then idle -> updateWeights exactly 16 cycles after the pending load.
  - Repeat with reset low at cycle 8 -> no strobe ever, pending dropped.
- Reserved header: byte C0 -> err_opcode=1 and the byte is dropped; a following COUNT(01,02) is still issued correctly.

Source files
------------

// File: rtl/pedo_pkg.sv
// Shared definitions for the pedometer command sequencer: header opcodes,
// operand widths and the sequencer state encoding.
package pedo_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_COUNT  = 2'b00;
    localparam logic [1:0] CMD_WEIGHT = 2'b01;
    localparam logic [1:0] CMD_FLUSH  = 2'b10;
    localparam logic [1:0] CMD_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_ARG0    = 3'd1,
        ST_ARG1    = 3'd2,
        ST_ISSUE_W = 3'd3,
        ST_ISSUE_D = 3'd4,
        ST_ISSUE_C = 3'd5
    } pedo_state_e;

endpackage

// File: rtl/pedo_frame_parser.sv
// Collects header + argument bytes from the host stream. frame_valid pulses
// combinationally in the cycle the final byte is accepted so the issuer can
// raise its strobe on that same edge.
module pedo_frame_parser
    import pedo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              o_frame_valid,
    output logic [1:0]        o_opcode,
    output logic [DATA_W-1:0] o_arg0,
    output logic [DATA_W-1:0] o_arg1,
    output logic              o_reserved,
    output pedo_state_e       o_state
);

    pedo_state_e       r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_arg0;
    logic              w_acc;
    logic [1:0]        w_hdr_op;

    assign in_ready = i_enable;
    assign w_acc    = in_valid & i_enable;
    assign w_hdr_op = in_data[7:6];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HDR;
            r_op    <= CMD_COUNT;
            r_arg0  <= '0;
        end else if (w_acc) begin
            case (r_state)
                ST_HDR: begin
                    // FLUSH and reserved headers are single-byte frames
                    if (w_hdr_op == CMD_COUNT || w_hdr_op == CMD_WEIGHT) begin
                        r_op    <= w_hdr_op;
                        r_state <= ST_ARG0;
                    end
                end
                ST_ARG0: begin
                    r_arg0  <= in_data;
                    r_state <= ST_ARG1;
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    assign o_frame_valid = w_acc && ((r_state == ST_ARG1) ||
                                     (r_state == ST_HDR && w_hdr_op == CMD_FLUSH));
    assign o_opcode      = (r_state == ST_HDR) ? w_hdr_op : r_op;
    assign o_arg0        = r_arg0;
    assign o_arg1        = in_data;
    assign o_reserved    = w_acc && (r_state == ST_HDR) && (w_hdr_op == CMD_RSVD);
    assign o_state       = r_state;

endmodule

// File: rtl/pedo_cmd_sequencer.sv
// Issues countSteps / updateWeights / dualUpdateWeights to the pedometer core,
// pairing consecutive weight writes into dual updates via a one-entry pending slot.
module pedo_cmd_sequencer
    import pedo_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 16,
    parameter int TMR_W         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              cmd_ready,
    output logic              countSteps,
    output logic              updateWeights,
    output logic              dualUpdateWeights,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [ADDR_W-1:0] Addr1,
    output logic [DATA_W-1:0] Data1,
    output logic [ADDR_W-1:0] Addr2,
    output logic [DATA_W-1:0] Data2,
    output logic              err_opcode,
    output pedo_state_e       o_dbg_state
);

    localparam logic             TMO_EN   = (FLUSH_TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(FLUSH_TIMEOUT - 1);

    pedo_state_e       r_state;
    logic              r_rdy;
    logic              r_cnt, r_upd, r_dual, r_err;
    logic [DATA_W-1:0] r_a, r_b, r_data1, r_data2;
    logic [ADDR_W-1:0] r_addr1, r_addr2;
    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_after_cnt;
    logic [DATA_W-1:0] r_cnt_a, r_cnt_b;
    logic [TMR_W-1:0]  r_tmr;

    logic              w_frame_valid, w_reserved, w_tmr_run;
    logic [1:0]        w_opcode;
    logic [DATA_W-1:0] w_arg0, w_arg1;
    logic [ADDR_W-1:0] w_waddr;
    pedo_state_e       w_parser_state;

    pedo_frame_parser u_parser (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (r_rdy),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .o_frame_valid(w_frame_valid),
        .o_opcode     (w_opcode),
        .o_arg0       (w_arg0),
        .o_arg1       (w_arg1),
        .o_reserved   (w_reserved),
        .o_state      (w_parser_state)
    );

    assign w_waddr   = w_arg0[ADDR_W-1:0];
    // Flush timer only ages a pending weight while the host is silent between frames
    assign w_tmr_run = TMO_EN && r_pend_v && (w_parser_state == ST_HDR) && !in_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HDR;
            r_rdy       <= 1'b0;
            r_cnt       <= 1'b0;
            r_upd       <= 1'b0;
            r_dual      <= 1'b0;
            r_err       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_addr1     <= '0;
            r_data1     <= '0;
            r_addr2     <= '0;
            r_data2     <= '0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_after_cnt <= 1'b0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_tmr       <= '0;
        end else begin
            case (r_state)
                ST_HDR: begin
                    r_rdy <= 1'b1;
                    if (w_reserved) r_err <= 1'b1;
                    if (w_frame_valid) begin
                        r_tmr <= '0;
                        case (w_opcode)
                            CMD_COUNT: begin
                                r_cnt_a <= w_arg0;
                                r_cnt_b <= w_arg1;
                                r_rdy   <= 1'b0;
                                // An older pending weight must reach the core before the count
                                if (r_pend_v) begin
                                    r_state     <= ST_ISSUE_W;
                                    r_after_cnt <= 1'b1;
                                    r_upd       <= 1'b1;
                                    r_addr1     <= r_pend_addr;
                                    r_data1     <= r_pend_data;
                                end else begin
                                    r_state <= ST_ISSUE_C;
                                    r_cnt   <= 1'b1;
                                    r_a     <= w_arg0;
                                    r_b     <= w_arg1;
                                end
                            end
                            CMD_WEIGHT: begin
                                if (!r_pend_v || r_pend_addr == w_waddr) begin
                                    r_pend_v    <= 1'b1;
                                    r_pend_addr <= w_waddr;
                                    r_pend_data <= w_arg1;
                                end else begin
                                    r_state <= ST_ISSUE_D;
                                    r_rdy   <= 1'b0;
                                    r_dual  <= 1'b1;
                                    r_addr1 <= r_pend_addr;
                                    r_data1 <= r_pend_data;
                                    r_addr2 <= w_waddr;
                                    r_data2 <= w_arg1;
                                end
                            end
                            default: begin
                                if (r_pend_v) begin
                                    r_state     <= ST_ISSUE_W;
                                    r_rdy       <= 1'b0;
                                    r_after_cnt <= 1'b0;
                                    r_upd       <= 1'b1;
                                    r_addr1     <= r_pend_addr;
                                    r_data1     <= r_pend_data;
                                end
                            end
                        endcase
                    end else if (w_tmr_run) begin
                        if (r_tmr == TMO_LAST) begin
                            r_tmr       <= '0;
                            r_state     <= ST_ISSUE_W;
                            r_rdy       <= 1'b0;
                            r_after_cnt <= 1'b0;
                            r_upd       <= 1'b1;
                            r_addr1     <= r_pend_addr;
                            r_data1     <= r_pend_data;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end else begin
                        r_tmr <= '0;
                    end
                end
                ST_ISSUE_W: begin
                    if (cmd_ready) begin
                        r_upd    <= 1'b0;
                        r_addr1  <= '0;
                        r_data1  <= '0;
                        r_pend_v <= 1'b0;
                        if (r_after_cnt) begin
                            r_state <= ST_ISSUE_C;
                            r_cnt   <= 1'b1;
                            r_a     <= r_cnt_a;
                            r_b     <= r_cnt_b;
                        end else begin
                            r_state <= ST_HDR;
                            r_rdy   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE_D: begin
                    if (cmd_ready) begin
                        r_dual   <= 1'b0;
                        r_addr1  <= '0;
                        r_data1  <= '0;
                        r_addr2  <= '0;
                        r_data2  <= '0;
                        r_pend_v <= 1'b0;
                        r_state  <= ST_HDR;
                        r_rdy    <= 1'b1;
                    end
                end
                ST_ISSUE_C: begin
                    if (cmd_ready) begin
                        r_cnt   <= 1'b0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_state <= ST_HDR;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_HDR;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign countSteps        = r_cnt;
    assign updateWeights     = r_upd;
    assign dualUpdateWeights = r_dual;
    assign A                 = r_a;
    assign B                 = r_b;
    assign Addr1             = r_addr1;
    assign Data1             = r_data1;
    assign Addr2             = r_addr2;
    assign Data2             = r_data2;
    assign err_opcode        = r_err;
    assign o_dbg_state       = (r_state == ST_HDR) ? w_parser_state : r_state;

endmodule
